chip_access_ctrl: RTL and testbench
===================================

Name: chip_access_ctrl

Overview:
Parametrised controller that runs one analog-array access per command: it drives the chip control strobes, instruction and addresses, and generates a gated chip clock from a programmable divider. After the access it captures the array output bits through a synchroniser and returns them on a valid/ready response channel. It sits between pinaipple_system's accelerator port and the chip pins, replacing the fixed free-running divide-by-10 clock.

Parameters:
DivWidth, 8, width of the half-period divide setting.
NcycWidth, 4, width of the extra-pulse count per command.
AddrColWidth, 5, column address width (array_col + mem_col).
AddrRowWidth, 5, row address width (array_row + mem_row).
NumArrays, 4, number of array output bits captured.

Ports:
clk_sys_in  input  1  system clock.
rst_sys_in  input  1  asynchronous active-low reset.
div_i  input  DivWidth  half-period of chip clock, minus 1, in sys cycles.
cmd_valid_i  input  1  command valid.
cmd_ready_o  output  1  command ready.
cmd_instr_i  input  2  11 form/prog, 10 read_mem, 01 read_reg, 00 inference.
cmd_ctrl_i  input  4  {CBL,CBLEN,CSL,CWL} levels for this access.
cmd_col_i  input  AddrColWidth  column address.
cmd_row_i  input  AddrRowWidth  row address.
cmd_ncyc_i  input  NcycWidth  chip-clock pulses minus 1.
abort_i  input  1  cancel the in-flight access.
rsp_valid_o  output  1  response valid.
rsp_ready_i  input  1  response ready.
rsp_data_o  output  NumArrays  captured array bits.
busy_o  output  1  high in any state except IDLE.
chip_clk_o  output  1  chip clock (clk_i pin).
cbl_o, cblen_o, csl_o, cwl_o  output  1 each  chip strobes.
instr_o  output  2  chip instruction.
addr_col_o  output  AddrColWidth  chip column address.
addr_row_o  output  AddrRowWidth  chip row address.
bit_in_i  input  NumArrays  array output bits, asynchronous to clk_sys_in.

Behaviour:
- Reset (async, rst_sys_in=0): state IDLE; every output 0 except cmd_ready_o=1. Synchroniser flops cleared.
- States: IDLE, SETUP, RUN, HOLD, RESP. All outputs registered.
- IDLE: cmd_ready_o=1, chip_clk_o=0, strobes 0, addr/instr hold last values. Accept on cmd_valid_i&cmd_ready_o at cycle t0. Latch the fields, latch div_i into D and cmd_ncyc_i into N; go to SETUP. div_i changes after accept have no effect.
- SETUP: from t0+1, strobes, instr and addr drive the latched values and stay constant until IDLE. chip_clk_o=0 for D+1 cycles, then go to RUN.
- RUN: chip_clk_o rises at t0+D+2. It toggles every D+1 cycles, giving N+1 full pulses (high D+1, low D+1). After the last falling edge, go to HOLD.
- HOLD: chip_clk_o=0 for D+1 cycles. At the end, register the synchronised bit_in_i into rsp_data_o and go to RESP.
- RESP: rsp_valid_o=1 from t0+D+2+(2N+2)(D+1). Hold rsp_data_o stable until rsp_ready_i; on the handshake go to IDLE with strobes 0 next cycle.
- Synchroniser: 2-flop per bit. rsp_data_o equals bit_in_i held stable for at least 3 sys cycles before rsp_valid_o rises.
- abort_i in SETUP/RUN/HOLD: next cycle IDLE, chip_clk_o=0, strobes 0, no response. In IDLE/RESP abort_i is ignored.
- Divider counter is DivWidth bits. D=0 gives chip clock = clk_sys_in/2. D=2^DivWidth-1 must not wrap incorrectly.
- N counter is NcycWidth bits. N=max gives 2^NcycWidth pulses.
- chip_clk_o is glitch-free: driven from a single flop.
- Reset mid-operation: immediate IDLE; chip_clk_o low asynchronously.

Test Plan:
- Reset with cmd_valid_i=1: all outputs 0 and cmd_ready_o=1 during reset; first accept occurs on the first clock after release.
- D=4, N=0, instr=10, col=5'h13, row=5'h07, bit_in_i=4'b1010: chip_clk_o high t0+6..t0+10; rsp_valid_o at t0+16; rsp_data_o=4'b1010; addr/instr stable t0+1 until IDLE.
- D=0, N=2: rising edges at t0+2, t0+4, t0+6; rsp_valid_o at t0+8. Hold rsp_ready_i=0 for 5 cycles: rsp_valid_o and data held, cmd_ready_o=0 throughout.
- abort_i at t0+7 of the D=4, N=0 case: chip_clk_o=0 and strobes 0 at t0+8; no rsp_valid_o; the next command is accepted normally.
- D=255, N=15: 16 pulses, each with a 256-cycle half-period; rsp at t0+257+32·256. Change div_i mid-access: the period is unaffected.
- bit_in_i toggling until 2 cycles before capture: the captured value is the old or new value, never a mix per bit. A value stable for 3 cycles is captured exactly.

Source files
------------

// File: rtl/chip_access_ctrl.sv
// Analog-array access controller: runs one strobed access per command with a
// programmable gated chip clock, then returns synchronised array bits.
module chip_access_ctrl #(
  parameter int DivWidth     = 8,
  parameter int NcycWidth    = 4,
  parameter int AddrColWidth = 5,
  parameter int AddrRowWidth = 5,
  parameter int NumArrays    = 4
) (
  input  logic                    clk_sys_in,
  input  logic                    rst_sys_in,
  input  logic [DivWidth-1:0]     div_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_instr_i,
  input  logic [3:0]              cmd_ctrl_i,
  input  logic [AddrColWidth-1:0] cmd_col_i,
  input  logic [AddrRowWidth-1:0] cmd_row_i,
  input  logic [NcycWidth-1:0]    cmd_ncyc_i,
  input  logic                    abort_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [NumArrays-1:0]    rsp_data_o,
  output logic                    busy_o,
  output logic                    chip_clk_o,
  output logic                    cbl_o,
  output logic                    cblen_o,
  output logic                    csl_o,
  output logic                    cwl_o,
  output logic [1:0]              instr_o,
  output logic [AddrColWidth-1:0] addr_col_o,
  output logic [AddrRowWidth-1:0] addr_row_o,
  input  logic [NumArrays-1:0]    bit_in_i,
  output logic [2:0]              dbg_state
);

  // Both channels use valid/ready: a transfer happens on the rising clk_sys_in
  // edge where valid and ready are both high; valid and its payload hold until then.
  typedef enum logic [2:0] {IDLE, SETUP, RUN, HOLD, RESP} state_t;

  state_t                 state_q, state_d;
  logic [DivWidth-1:0]    div_q, cnt_q, cnt_d;
  logic [NcycWidth-1:0]   ncyc_q, pcnt_q, pcnt_d;
  logic [NumArrays-1:0]   sync1_q, sync2_q;
  logic                   chip_clk_d;
  logic                   load;
  logic                   capture;
  logic                   phase_done;
  logic                   in_access;

  assign phase_done = (cnt_q == div_q);
  assign in_access  = (state_q == SETUP) || (state_q == RUN) || (state_q == HOLD);
  assign dbg_state  = state_q;

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // cnt_q counts sys cycles within one chip-clock phase; it restarts at every
  // phase boundary, so a divide setting of all ones never needs to wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    pcnt_d     = pcnt_q;
    chip_clk_d = chip_clk_o;
    load       = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pcnt_d = '0;
        if (cmd_valid_i) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_d    = RUN;
          cnt_d      = '0;
          chip_clk_d = 1'b1;
        end
      end
      RUN: begin
        if (phase_done) begin
          cnt_d = '0;
          if (!chip_clk_o) begin
            chip_clk_d = 1'b1;
          end else begin
            chip_clk_d = 1'b0;
            if (pcnt_q == ncyc_q) state_d = HOLD;
            else                  pcnt_d  = pcnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_done) begin
          state_d = RESP;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && in_access) begin
      state_d    = IDLE;
      chip_clk_d = 1'b0;
      capture    = 1'b0;
    end
  end

  // Every pin is a flop; the chip clock comes from one flop so it cannot glitch.
  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      div_q       <= '0;
      ncyc_q      <= '0;
      chip_clk_o  <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      cbl_o       <= 1'b0;
      cblen_o     <= 1'b0;
      csl_o       <= 1'b0;
      cwl_o       <= 1'b0;
      instr_o     <= '0;
      addr_col_o  <= '0;
      addr_row_o  <= '0;
    end else begin
      chip_clk_o  <= chip_clk_d;
      cmd_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      rsp_valid_o <= (state_d == RESP);
      if (load) begin
        div_q                         <= div_i;
        ncyc_q                        <= cmd_ncyc_i;
        {cbl_o, cblen_o, csl_o, cwl_o} <= cmd_ctrl_i;
        instr_o                       <= cmd_instr_i;
        addr_col_o                    <= cmd_col_i;
        addr_row_o                    <= cmd_row_i;
      end else if (state_d == IDLE) begin
        {cbl_o, cblen_o, csl_o, cwl_o} <= 4'b0000;
      end
      if (capture) rsp_data_o <= sync2_q;
    end
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bit_in_i;
      sync2_q <= sync1_q;
    end
  end

endmodule

// File: tb/tb_chip_access_ctrl.sv
// Bench for chip_access_ctrl: timing and data expectations come from the
// access-time formulas and are checked by a free-running monitor.
module tb_chip_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] div_i;
  logic       cmd_valid;
  logic       cmd_ready_o;
  logic [1:0] cmd_instr;
  logic [3:0] cmd_ctrl;
  logic [4:0] cmd_col;
  logic [4:0] cmd_row;
  logic [3:0] cmd_ncyc;
  logic       abort;
  logic       rsp_valid_o;
  logic       rsp_ready;
  logic [3:0] rsp_data_o;
  logic       busy_o;
  logic       chip_clk_o;
  logic       cbl_o, cblen_o, csl_o, cwl_o;
  logic [1:0] instr_o;
  logic [4:0] addr_col_o;
  logic [4:0] addr_row_o;
  logic [3:0] bit_in;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_rise_q[$];
  logic [31:0] exp_time_q[$];
  logic [3:0]  exp_q[$];

  logic [3:0] cur_ctrl;
  logic [1:0] cur_instr;
  logic [4:0] cur_col;
  logic [4:0] cur_row;

  chip_access_ctrl dut (
    .clk_sys_in (clk),
    .rst_sys_in (rst_n),
    .div_i      (div_i),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_instr_i(cmd_instr),
    .cmd_ctrl_i (cmd_ctrl),
    .cmd_col_i  (cmd_col),
    .cmd_row_i  (cmd_row),
    .cmd_ncyc_i (cmd_ncyc),
    .abort_i    (abort),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data_o),
    .busy_o     (busy_o),
    .chip_clk_o (chip_clk_o),
    .cbl_o      (cbl_o),
    .cblen_o    (cblen_o),
    .csl_o      (csl_o),
    .cwl_o      (cwl_o),
    .instr_o    (instr_o),
    .addr_col_o (addr_col_o),
    .addr_row_o (addr_row_o),
    .bit_in_i   (bit_in),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle index: a value seen at the negedge with cyc == m is the
  // value the design presents at cycle m+1.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks invariants, chip-clock rising edges and responses.
  logic prev_clk   = 1'b0;
  logic prev_valid = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("ready_vs_busy", cmd_ready_o, !busy_o);
      if (busy_o)
        chk("pins_during_access",
            {cbl_o, cblen_o, csl_o, cwl_o, instr_o, addr_col_o, addr_row_o},
            {cur_ctrl, cur_instr, cur_col, cur_row});
      else
        chk("idle_quiet", {cbl_o, cblen_o, csl_o, cwl_o, chip_clk_o, rsp_valid_o}, 0);
      if (chip_clk_o && !prev_clk) begin
        if (exp_rise_q.size() == 0) chk("rise_unexpected", cyc + 1, 0);
        else chk("rise_time", cyc + 1, exp_rise_q.pop_front());
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid_o, 0);
        end else begin
          if (!prev_valid) begin
            if (exp_time_q.size() == 0) chk("rsp_time_missing", cyc + 1, 0);
            else chk("rsp_time", cyc + 1, exp_time_q.pop_front());
          end
          chk("rsp_data", rsp_data_o, exp_q[0]);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
    prev_clk   = chip_clk_o;
    prev_valid = rsp_valid_o;
  end

  // Driver: one command; abort_at < 0 means run to completion.
  task automatic run_cmd(input int d, input int n, input logic [1:0] instr,
                         input logic [3:0] ctrl, input logic [4:0] col, input logic [4:0] row,
                         input logic [3:0] final_bits, input int abort_at,
                         input bit toggle, input int hold_cycles);
    int t0, t_rsp, budget, r;
    budget = 0;
    while (!cmd_ready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready_o) begin
      chk("cmd_ready_timeout", cmd_ready_o, 1);
      return;
    end
    div_i     = 8'(d);
    cmd_ncyc  = 4'(n);
    cmd_instr = instr;
    cmd_ctrl  = ctrl;
    cmd_col   = col;
    cmd_row   = row;
    cmd_valid = 1'b1;
    cur_instr = instr;
    cur_ctrl  = ctrl;
    cur_col   = col;
    cur_row   = row;
    t0    = cyc + 1;
    t_rsp = t0 + d + 2 + (2 * n + 2) * (d + 1);
    for (int k = 0; k <= n; k++) begin
      r = t0 + d + 2 + 2 * k * (d + 1);
      if (abort_at < 0 || r <= t0 + abort_at) exp_rise_q.push_back(r);
    end
    if (abort_at < 0) begin
      exp_time_q.push_back(t_rsp);
      exp_q.push_back(final_bits);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept", {busy_o, cmd_ready_o}, 2'b10);
    while (cyc < t_rsp - 4) begin
      div_i     = 8'($urandom);
      cmd_instr = 2'($urandom);
      cmd_ctrl  = 4'($urandom);
      cmd_col   = 5'($urandom);
      cmd_row   = 5'($urandom);
      cmd_ncyc  = 4'($urandom);
      if (toggle) bit_in = 4'($urandom);
      if (abort_at >= 0 && cyc == t0 + abort_at - 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy_o, chip_clk_o, cbl_o, cblen_o, csl_o, cwl_o, rsp_valid_o}, 0);
        return;
      end
      @(negedge clk);
    end
    bit_in = final_bits;
    budget = 0;
    while (!rsp_valid_o && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!rsp_valid_o) begin
      chk("rsp_valid_timeout", rsp_valid_o, 1);
      return;
    end
    repeat (hold_cycles) begin
      bit_in = 4'($urandom);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release", busy_o, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_instr = 2'b01;
    cmd_ctrl  = 4'b0110;
    cmd_col   = 5'h0a;
    cmd_row   = 5'h15;
    cmd_ncyc  = 4'd1;
    div_i     = 8'd3;
    abort     = 1'b0;
    rsp_ready = 1'b0;
    bit_in    = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_ready", cmd_ready_o, 1);
    chk("reset_outputs", {busy_o, rsp_valid_o, rsp_data_o, chip_clk_o, cbl_o, cblen_o, csl_o,
                          cwl_o, instr_o, addr_col_o, addr_row_o, dbg_state}, 0);
    rst_n = 1'b1;
    // Valid is already high, so the first edge after release must accept.
    run_cmd(3, 1, 2'b01, 4'b0110, 5'h0a, 5'h15, 4'b0101, -1, 1'b0, 0);
    run_cmd(4, 0, 2'b10, 4'b1011, 5'h13, 5'h07, 4'b1010, -1, 1'b0, 0);
    run_cmd(0, 2, 2'b11, 4'b1111, 5'h1f, 5'h00, 4'b0011, -1, 1'b0, 5);
    run_cmd(4, 0, 2'b10, 4'b1101, 5'h13, 5'h07, 4'b1111, 7, 1'b0, 0);
    run_cmd(1, 1, 2'b00, 4'b0001, 5'h02, 5'h1c, 4'b1001, -1, 1'b1, 2);
    for (int i = 0; i < 12; i++) begin
      int d, n, ab;
      d  = $urandom_range(0, 6);
      n  = $urandom_range(0, 3);
      ab = -1;
      if (d >= 2 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, d + 1);
      run_cmd(d, n, 2'($urandom), 4'($urandom), 5'($urandom), 5'($urandom),
              4'($urandom), ab, 1'($urandom), $urandom_range(0, 4));
    end
    run_cmd(255, 15, 2'b10, 4'b1010, 5'h11, 5'h0e, 4'b0110, -1, 1'b1, 1);
    repeat (4) @(negedge clk);
    chk("rise_queue_empty", exp_rise_q.size(), 0);
    chk("rsp_queue_empty", exp_q.size(), 0);
    chk("time_queue_empty", exp_time_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: cycle budget of 60000 exhausted");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
